// File: rtl/cook_timer_ctrl.sv
// Purpose: sequencing FSM for a microwave cook-time countdown chain (load, 1 Hz gating, pause, done).
// Latency: loads, mag_on and done are registered one cycle after the trigger; cnt_en is same-cycle.
// Backpressure: none; pulses arriving in states that do not use them are dropped, not queued.
module cook_timer_ctrl #(
    parameter int DONE_TICKS = 5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick,
    input  logic       key_valid,
    input  logic       start,
    input  logic       stop_cancel,
    input  logic       door_closed,
    input  logic       time_zero,
    output logic       load_n,
    output logic       load_zero,
    output logic       cnt_en,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SET    = 3'd1;
    localparam logic [2:0] COOK   = 3'd2;
    localparam logic [2:0] PAUSED = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0] state_nxt;
    logic       load_nxt;
    logic       zero_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic [3:0] done_cnt;
    logic       can_start;

    assign can_start = start & door_closed & ~time_zero;

    // Decrement gating is combinational from the registered state so the chain sees it this cycle.
    assign cnt_en = tick & (state == COOK) & ~time_zero;

    always_comb begin
        state_nxt = state;
        load_nxt  = 1'b0;
        zero_nxt  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    state_nxt = SET;
                    load_nxt  = 1'b1;
                end
            end
            SET: begin
                if (stop_cancel) begin
                    state_nxt = IDLE;
                    load_nxt  = 1'b1;
                    zero_nxt  = 1'b1;
                end else if (key_valid) begin
                    load_nxt  = 1'b1;
                end else if (can_start) begin
                    state_nxt = COOK;
                end
            end
            COOK: begin
                if (stop_cancel || !door_closed) begin
                    state_nxt = PAUSED;
                end else if (time_zero) begin
                    state_nxt = DONE;
                    cnt_clr   = 1'b1;
                end
            end
            PAUSED: begin
                if (stop_cancel) begin
                    state_nxt = IDLE;
                    load_nxt  = 1'b1;
                    zero_nxt  = 1'b1;
                end else if (can_start) begin
                    state_nxt = COOK;
                end
            end
            DONE: begin
                if (stop_cancel || !door_closed) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (done_cnt == 4'(DONE_TICKS - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            load_n    <= 1'b1;
            load_zero <= 1'b0;
            mag_on    <= 1'b0;
            done      <= 1'b0;
            done_cnt  <= 4'd0;
        end else begin
            state     <= state_nxt;
            load_n    <= ~load_nxt;
            load_zero <= zero_nxt;
            mag_on    <= (state_nxt == COOK);
            done      <= (state_nxt == DONE);
            if (cnt_clr) begin
                done_cnt <= 4'd0;
            end else if (cnt_inc) begin
                done_cnt <= done_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl with a behavioural seconds-counter standing in for the digit chain.
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop_cancel = 1'b0;
    logic       door_closed = 1'b1;
    logic       time_zero;
    logic       load_n, load_zero, cnt_en, mag_on, done;
    logic [2:0] state;

    int secs = 0;
    int keypad = 0;
    int n_en = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cook_timer_ctrl #(.DONE_TICKS(5)) dut (
        .clk(clk), .clear(clear), .tick(tick), .key_valid(key_valid),
        .start(start), .stop_cancel(stop_cancel), .door_closed(door_closed),
        .time_zero(time_zero), .load_n(load_n), .load_zero(load_zero),
        .cnt_en(cnt_en), .mag_on(mag_on), .done(done), .state(state)
    );

    // Chain model: a decrement at zero wraps to 59:59 so a bad wrap is visible.
    assign time_zero = (secs == 0);
    always @(posedge clk) begin
        if (!load_n)     secs <= load_zero ? 0 : keypad;
        else if (cnt_en) secs <= (secs == 0) ? 3599 : secs - 1;
        if (cnt_en) n_en <= n_en + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic one_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic key_in(input int v);
        keypad = v;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en0;
        // Reset values while clear is low, tick high
        tick = 1'b1;
        cyc(); cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_load_n", int'(load_n), 1);
        chk("rst_load_zero", int'(load_zero), 0);
        chk("rst_mag_on", int'(mag_on), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        tick = 1'b0;
        clear = 1'b1;
        cyc();

        // Cook 00:03 to completion
        keypad = 3;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        chk("t1_state_set", int'(state), 1);
        chk("t1_load_n_low", int'(load_n), 0);
        chk("t1_load_zero", int'(load_zero), 0);
        cyc();
        chk("t1_load_n_high", int'(load_n), 1);
        chk("t1_secs", secs, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_state_cook", int'(state), 2);
        chk("t1_mag_on", int'(mag_on), 1);
        en0 = n_en;
        for (int i = 0; i < 3; i++) one_tick();
        chk("t1_en_pulses", n_en - en0, 3);
        chk("t1_state_done", int'(state), 4);
        chk("t1_done", int'(done), 1);
        chk("t1_mag_off", int'(mag_on), 0);
        for (int i = 0; i < 4; i++) one_tick();
        chk("t1_still_done", int'(done), 1);
        chk("t1_still_done_state", int'(state), 4);
        one_tick();
        chk("t1_idle", int'(state), 0);
        chk("t1_done_off", int'(done), 0);
        chk("t1_secs_zero", secs, 0);

        // Cook 01:00, pause on door, resume from 00:50
        key_in(60);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 10; i++) one_tick();
        chk("t2_secs50", secs, 50);
        door_closed = 1'b0;
        cyc();
        chk("t2_paused", int'(state), 3);
        chk("t2_mag_off", int'(mag_on), 0);
        en0 = n_en;
        for (int i = 0; i < 3; i++) one_tick();
        chk("t2_no_en", n_en - en0, 0);
        door_closed = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2_resume", int'(state), 2);
        chk("t2_mag_on", int'(mag_on), 1);
        chk("t2_secs_held", secs, 50);
        one_tick();
        chk("t2_secs49", secs, 49);
        // Tick coinciding with stop: still decrements on the exit edge
        tick = 1'b1;
        stop_cancel = 1'b1;
        cyc();
        tick = 1'b0;
        stop_cancel = 1'b0;
        chk("t2_exit_paused", int'(state), 3);
        chk("t2_secs48", secs, 48);

        // PAUSED: start + stop_cancel together cancels with a zero load
        start = 1'b1;
        stop_cancel = 1'b1;
        cyc();
        start = 1'b0;
        stop_cancel = 1'b0;
        chk("t3_p_idle", int'(state), 0);
        chk("t3_p_load_n", int'(load_n), 0);
        chk("t3_p_load_zero", int'(load_zero), 1);
        cyc();
        chk("t3_p_load_n_high", int'(load_n), 1);
        chk("t3_p_secs", secs, 0);

        // SET: cancel clears the chain
        key_in(7);
        chk("t3_s_secs7", secs, 7);
        stop_cancel = 1'b1;
        cyc();
        stop_cancel = 1'b0;
        chk("t3_s_idle", int'(state), 0);
        chk("t3_s_load_n", int'(load_n), 0);
        chk("t3_s_load_zero", int'(load_zero), 1);
        cyc();
        chk("t3_s_secs", secs, 0);

        // SET with 00:00: start ignored, no decrement, no wrap
        key_in(0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_zero_set", int'(state), 1);
        en0 = n_en;
        for (int i = 0; i < 2; i++) one_tick();
        chk("t4_no_en", n_en - en0, 0);
        chk("t4_no_wrap", secs, 0);
        // SET with door open: start ignored
        key_in(5);
        door_closed = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_door_set", int'(state), 1);
        chk("t5_door_mag", int'(mag_on), 0);
        door_closed = 1'b1;

        // Async clear mid-COOK with tick high
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_cook", int'(state), 2);
        tick = 1'b1;
        #2;
        clear = 1'b0;
        #1;
        chk("t6_clr_state", int'(state), 0);
        chk("t6_clr_mag", int'(mag_on), 0);
        chk("t6_clr_cnt_en", int'(cnt_en), 0);
        chk("t6_clr_load_n", int'(load_n), 1);
        chk("t6_clr_done", int'(done), 0);
        tick = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_start_ignored", int'(state), 0);
        chk("t6_start_no_mag", int'(mag_on), 0);
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        chk("t6_key_set", int'(state), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
